// File: rtl/fetch_buffer.sv
// Instruction prefetch stage: sequential word reads into a small PC-tagged FIFO
// feeding the decoder, with branch-redirect flush that discards an in-flight read.
module fetch_buffer #(
  parameter int              DEPTH    = 4,
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              PC_STEP  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   halt,
  input  logic                   flush,
  input  logic [AW-1:0]          flush_addr,
  output logic                   mem_re,
  output logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_data_r,
  input  logic                   mem_rdy,
  output logic [DW-1:0]          instr,
  output logic [AW-1:0]          instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } entry_t;

  state_t        r_state, w_state_nxt;
  entry_t        r_fifo [DEPTH];
  entry_t        r_head, w_head_nxt;
  logic [PW-1:0] r_wptr, r_rptr, w_rptr_nxt;
  logic [CW-1:0] r_count, w_count_pop, w_count_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt, r_mem_addr;
  logic          r_halt;
  logic          w_push, w_pop, w_start, w_new_req;

  assign w_pop       = instr_valid & instr_ready & ~flush;
  assign w_push      = (r_state == FETCH) & mem_rdy & ~flush;
  assign w_count_pop = r_count - CW'(w_pop);
  assign w_count_nxt = flush ? '0 : w_count_pop + CW'(w_push);
  assign w_rptr_nxt  = r_rptr + PW'(w_pop);
  // Gating on post-update occupancy makes the outstanding read own a free slot.
  assign w_start     = en & ~halt & ~r_halt & ~flush & (w_count_nxt < CW'(DEPTH));

  always_comb begin
    w_pc_nxt = r_pc;
    if (flush)
      w_pc_nxt = flush_addr;
    else if ((r_state == FETCH) && mem_rdy)
      w_pc_nxt = r_pc + AW'(PC_STEP);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_new_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = FETCH;
          w_new_req   = 1'b1;
        end
      end
      FETCH: begin
        if (mem_rdy) begin
          w_state_nxt = w_start ? FETCH : IDLE;
          w_new_req   = w_start;
        end else if (flush) begin
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_rdy) begin
          w_state_nxt = w_start ? FETCH : IDLE;
          w_new_req   = w_start;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Head register bypasses the array when a word lands in an (effectively) empty FIFO.
  always_comb begin
    w_head_nxt = r_fifo[w_rptr_nxt];
    if (w_push && (w_count_pop == '0))
      w_head_nxt = '{data: mem_data_r, pc: r_pc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_halt     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      r_halt  <= r_halt | halt;
      if (w_new_req)
        r_mem_addr <= w_pc_nxt;
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + 1'b1;
        r_rptr <= w_rptr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr] <= '{data: mem_data_r, pc: r_pc};
  end

  assign mem_re      = (r_state != IDLE);
  assign mem_addr    = r_mem_addr;
  assign instr       = r_head.data;
  assign instr_pc    = r_head.pc;
  assign instr_valid = (r_count != '0);
  assign count       = r_count;

endmodule
